// File: rtl/mul_pkg.sv
// Shared definitions for the 3x3 multiplier arbiter slice.
// Holds the result-register state encoding and the datapath widths used by
// mul3_arbiter and mul3x3_unit.
package mul_pkg;

  // Operand width of each multiplicand/multiplier.
  localparam int OPW  = 3;
  // Full-precision product width (7*7 = 49 fits in 6 bits).
  localparam int PW   = 6;
  // Width of the completed-transfer counter.
  localparam int CNTW = 16;

  // Result register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : mul_pkg

// File: rtl/mul3x3_unit.sv
// Combinational 3x3 unsigned multiplier built as a partial-product/adder
// array. Each multiplier bit gates a shifted copy of the multiplicand and the
// gated rows are summed at full product width, so nothing is truncated.
//
// Ports:
//   a_i  in   OPW  multiplicand
//   b_i  in   OPW  multiplier
//   p_o  out  PW   unsigned product a_i * b_i
module mul3x3_unit
  import mul_pkg::*;
(
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic [PW-1:0]  p_o
);

  logic [PW-1:0] pp [OPW];

  // Row j is the multiplicand ANDed with multiplier bit j, weighted by 2^j.
  always_comb begin
    for (int j = 0; j < OPW; j++) begin
      pp[j] = PW'(a_i & {OPW{b_i[j]}}) << j;
    end
  end

  always_comb begin
    p_o = '0;
    // NOTE: blocking assignments here build a running sum within one
    // evaluation; non-blocking would only keep the last row.
    for (int j = 0; j < OPW; j++) begin
      p_o = p_o + pp[j];
    end
  end

endmodule : mul3x3_unit

// File: rtl/mul3_arbiter.sv
// Round-robin arbiter sharing one 3x3 multiplier among NREQ requesters.
// A single result register (EMPTY/FULL) holds the product and the owner ID.
// A new grant is allowed when the register is empty or is being drained in the
// same cycle, giving one result per cycle under continuous load.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   req_valid  in   NREQ     per-requester operand valid
//   req_a      in   3*NREQ   multiplicands, requester i at [3i+2:3i]
//   req_b      in   3*NREQ   multipliers, requester i at [3i+2:3i]
//   req_ready  out  NREQ     one-hot accept (combinational)
//   res_valid  out  1        result register holds a product
//   res_p      out  6        product
//   res_id     out  IDW      owner of res_p
//   res_ready  in   1        consumer accepts result
//   ops_cnt    out  16       completed result transfers, wrapping
module mul3_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic [PW-1:0]       res_p,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready,
  output logic [CNTW-1:0]     ops_cnt
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]   res_p_q, res_p_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  rr_idx;
  logic            accept;
  logic            drain;
  logic [OPW-1:0]  a_sel, b_sel;
  logic [PW-1:0]   prod;

  // Round-robin search: scan ptr+1, ptr+2, ... wrapping, ending at ptr itself,
  // so the last winner has lowest priority.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  // Only the granted requester's operands reach the multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[OPW*i +: OPW];
        b_sel = req_b[OPW*i +: OPW];
      end
    end
  end

  mul3x3_unit u_mul (
    .a_i (a_sel),
    .b_i (b_sel),
    .p_o (prod)
  );

  // A slot is free when empty or when the held result leaves this cycle.
  assign drain     = (state_q == FULL) && res_ready;
  assign accept    = !rst && gnt_any && ((state_q == EMPTY) || res_ready);
  assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    res_p_d  = res_p_q;
    res_id_d = res_id_q;
    cnt_d    = cnt_q;

    if (drain) begin
      cnt_d = cnt_q + CNTW'(1);
    end

    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      ptr_d    = gnt_idx;
      res_p_d  = prod;
      res_id_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= IDW'(NREQ - 1);
      res_p_q  <= '0;
      res_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      res_p_q  <= res_p_d;
      res_id_q <= res_id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;
  assign ops_cnt   = cnt_q;

endmodule : mul3_arbiter

// File: tb/tb_mul3_arbiter.sv
module tb_mul3_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [3*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0] req_ready;
  logic            res_valid;
  logic [5:0]      res_p;
  logic [IDW-1:0]  res_id;
  logic            res_ready;
  logic [15:0]     ops_cnt;

  always #5 clk = ~clk;

  mul3_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_p     (res_p),
    .res_id    (res_id),
    .res_ready (res_ready),
    .ops_cnt   (ops_cnt)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [5:0]     p;
  } res_t;

  res_t        sb[$];
  bit          m_full;
  logic [1:0]  m_ptr;
  logic [15:0] m_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic void rr_model(input logic [3:0] v, input logic [1:0] ptr,
                                   output bit found, output logic [1:0] g);
    found = 0;
    g     = '0;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(ptr) + k) % 4;
      if (!found && v[idx]) begin
        found = 1;
        g     = 2'(idx);
      end
    end
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[3*i +: 3] = 3'(a);
    req_b[3*i +: 3] = 3'(b);
  endtask

  // One clock cycle: compare outputs with the model/scoreboard, then advance
  // the model across the rising edge. Entered and left just after a negedge.
  task automatic tick();
    bit         found;
    logic [1:0] g;
    logic [3:0] exp_rdy;
    logic [2:0] av, bv;
    res_t       e;
    #1;
    rr_model(req_valid, m_ptr, found, g);
    exp_rdy = (!rst && found && (!m_full || res_ready)) ? 4'(1 << g) : 4'b0;
    n_checks++;
    if (req_ready !== exp_rdy) $display("FAIL sb_ready got %b want %b", req_ready, exp_rdy);
    else n_pass++;
    n_checks++;
    if (res_valid !== m_full) $display("FAIL sb_res_valid got %b want %b", res_valid, m_full);
    else n_pass++;
    n_checks++;
    if (ops_cnt !== m_cnt) $display("FAIL sb_ops_cnt got %0d want %0d", ops_cnt, m_cnt);
    else n_pass++;
    if (m_full && sb.size() > 0) begin
      e = sb[0];
      n_checks++;
      if (res_p !== e.p) $display("FAIL sb_res_p got %0d want %0d", res_p, e.p);
      else n_pass++;
      n_checks++;
      if (res_id !== e.id) $display("FAIL sb_res_id got %0d want %0d", res_id, e.id);
      else n_pass++;
    end
    @(posedge clk);
    if (rst) begin
      m_full = 0;
      m_ptr  = 2'd3;
      m_cnt  = '0;
      sb.delete();
    end else begin
      if (m_full && res_ready) begin
        void'(sb.pop_front());
        m_cnt++;
      end
      if (exp_rdy != 0) begin
        av   = 3'(req_a >> (3 * int'(g)));
        bv   = 3'(req_b >> (3 * int'(g)));
        e.id = g;
        e.p  = 6'(int'(av) * int'(bv));
        sb.push_back(e);
        m_ptr = g;
      end
      m_full = (exp_rdy != 0) || (m_full && !res_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    m_full = 0;
    m_ptr  = 2'd3;
    m_cnt  = '0;
    req_valid = 4'hF;
    tick();
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid);
    else n_pass++;
    n_checks++;
    if (res_p !== 6'd0) $display("FAIL reset_res_p got %0d want 0", res_p);
    else n_pass++;
    n_checks++;
    if (res_id !== 2'd0) $display("FAIL reset_res_id got %0d want 0", res_id);
    else n_pass++;
    n_checks++;
    if (ops_cnt !== 16'd0) $display("FAIL reset_ops_cnt got %0d want 0", ops_cnt);
    else n_pass++;
    n_checks++;
    if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", req_ready);
    else n_pass++;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    set_op(0, 5, 6);
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL single_valid got %b want 1", res_valid);
    else n_pass++;
    n_checks++;
    if (res_p !== 6'd30) $display("FAIL single_p got %0d want 30", res_p);
    else n_pass++;
    n_checks++;
    if (res_id !== 2'd0) $display("FAIL single_id got %0d want 0", res_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 7);
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << (k % 4)))
        $display("FAIL fair_grant_%0d got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (res_p !== 6'(7 * ((k - 1) % 4 + 1)))
          $display("FAIL fair_p_%0d got %0d want %0d", k, res_p, 7 * ((k - 1) % 4 + 1));
        else n_pass++;
      end
      tick();
    end
    req_valid = '0;
    #1;
    n_checks++;
    if (res_p !== 6'd7 || res_id !== 2'd0)
      $display("FAIL fair_last got p=%0d id=%0d want p=7 id=0", res_p, res_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0001;
    set_op(0, 3, 5);
    res_ready = 1'b0;
    tick();
    req_valid = 4'b0010;
    set_op(1, 7, 7);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0) $display("FAIL bp_ready_%0d got %b want 0000", k, req_ready);
      else n_pass++;
      n_checks++;
      if (res_p !== 6'd15 || res_id !== 2'd0)
        $display("FAIL bp_hold_%0d got p=%0d id=%0d want p=15 id=0", k, res_p, res_id);
      else n_pass++;
      tick();
    end
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release got %b want 0010", req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (res_p !== 6'd49 || res_id !== 2'd1)
      $display("FAIL bp_result got p=%0d id=%0d want p=49 id=1", res_p, res_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_exhaustive();
    req_valid = 4'b0100;
    res_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        set_op(2, a, b);
        tick();
      end
    end
    req_valid = '0;
    #1;
    n_checks++;
    if (res_p !== 6'd49 || res_id !== 2'd2)
      $display("FAIL exh_corner got p=%0d id=%0d want p=49 id=2", res_p, res_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b0010;
    set_op(1, 6, 7);
    res_ready = 1'b0;
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (res_p !== 6'd42) $display("FAIL mid_held got %0d want 42", res_p);
    else n_pass++;
    rst = 1'b1;
    res_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || ops_cnt !== 16'd0)
      $display("FAIL mid_cleared got valid=%b cnt=%0d want valid=0 cnt=0", res_valid, ops_cnt);
    else n_pass++;
    req_valid = 4'b1010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL mid_first_grant got %b want 0010", req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_cnt_wrap();
    int guard = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 1, 1);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (ops_cnt !== 16'hFFFF) $display("FAIL wrap_pre got %h want ffff", ops_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (ops_cnt !== 16'h0000) $display("FAIL wrap_post got %h want 0000", ops_cnt);
    else n_pass++;
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_exhaustive();
    test_reset_midop();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mul3_arbiter
